// File: rtl/wallace_mult_pipe_if.sv
// Operand/result handshake bundle for wallace_mult_pipe.
// The producer drives the in_* side and the consumer drives out_ready_i.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   multiplier_i;
  logic [WIDTH-1:0]   multiplicand_i;
  logic               signed_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [2*WIDTH-1:0] product_o;
  logic               signed_o;

  modport master (
    output in_valid_i,
    output multiplier_i,
    output multiplicand_i,
    output signed_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  product_o,
    input  signed_o
  );

  modport slave (
    input  in_valid_i,
    input  multiplier_i,
    input  multiplicand_i,
    input  signed_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output product_o,
    output signed_o
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined signed/unsigned Wallace-tree multiplier with a global-stall
// valid/ready pipe; in_ready_o depends combinationally on out_ready_i.
module wallace_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  wallace_mult_pipe_if.slave bus
);
  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH + 1;
  localparam int MID  = STAGES - 2;
  localparam int NM   = (MID > 0) ? MID : 1;

  typedef logic [ROWS-1:0][PW-1:0] rows_t;

  function automatic int rows_after(input int n);
    int r;
    r = ROWS;
    for (int l = 0; l < ROWS; l++)
      if (l < n && r > 2) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int num_levels();
    int n;
    n = 0;
    for (int l = 0; l < ROWS; l++)
      if (rows_after(l) > 2) n++;
    return n;
  endfunction

  localparam int LV = num_levels();

  function automatic rows_t gen_pp(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sg
  );
    rows_t pp;
    logic  t;
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        t = a[i] & b[j];
        // Baugh-Wooley: MSB row/column terms inverted, corner term kept
        if (sg && ((i == WIDTH - 1) != (j == WIDTH - 1))) t = ~t;
        pp[i][i+j] = t;
      end
    end
    pp[WIDTH][WIDTH] = sg;
    pp[WIDTH][PW-1]  = sg;
    return pp;
  endfunction

  function automatic rows_t csa(input rows_t x, input int r);
    rows_t y;
    int    g3;
    y  = '0;
    g3 = r / 3;
    for (int g = 0; g < ROWS / 3; g++) begin
      if (g < g3) begin
        y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
        y[2*g+1] = ((x[3*g] & x[3*g+1]) |
                    (x[3*g] & x[3*g+2]) |
                    (x[3*g+1] & x[3*g+2])) << 1;
      end
    end
    // leftover rows pass straight through behind the compressed pairs
    for (int i = 0; i < ROWS; i++)
      if (i >= 3 * g3 && i < r) y[i-g3] = x[i];
    return y;
  endfunction

  function automatic rows_t reduce(
    input rows_t x,
    input int    lo,
    input int    hi
  );
    rows_t y;
    y = x;
    for (int l = 0; l < ROWS; l++)
      if (l >= lo && l < hi) y = csa(y, rows_after(l));
    return y;
  endfunction

  function automatic logic [PW-1:0] cpa(input rows_t x);
    return x[0] + x[1];
  endfunction

  logic              adv;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] s_q, s_d;
  logic [WIDTH-1:0]  a_q, b_q;
  rows_t             mid_q [NM];
  rows_t             mid_d [NM];
  rows_t             fin;
  logic [PW-1:0]     p_q, p_d;

  assign adv             = ~v_q[STAGES-1] | bus.out_ready_i;
  assign bus.in_ready_o  = adv;
  assign bus.out_valid_o = v_q[STAGES-1];
  assign bus.product_o   = p_q;
  assign bus.signed_o    = s_q[STAGES-1];

  assign v_d = {v_q[STAGES-2:0], bus.in_valid_i};
  assign s_d = {s_q[STAGES-2:0], bus.signed_i};

  if (MID > 0) begin : g_mid
    for (genvar t = 0; t < MID; t++) begin : g_lvl
      if (t == 0) begin : g_first
        assign mid_d[t] = reduce(gen_pp(a_q, b_q, s_q[0]),
                                 0, LV / MID);
      end else begin : g_next
        assign mid_d[t] = reduce(mid_q[t-1],
                                 t * LV / MID,
                                 (t + 1) * LV / MID);
      end
    end
    assign fin = mid_q[MID-1];
  end else begin : g_flat
    assign mid_d[0] = '0;
    assign fin      = reduce(gen_pp(a_q, b_q, s_q[0]), 0, LV);
  end

  assign p_d = cpa(fin);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
      s_q <= '0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      for (int t = 0; t < NM; t++) mid_q[t] <= '0;
    end else if (adv) begin
      v_q <= v_d;
      s_q <= s_d;
      a_q <= bus.multiplier_i;
      b_q <= bus.multiplicand_i;
      p_q <= p_d;
      for (int t = 0; t < NM; t++) mid_q[t] <= mid_d[t];
    end
  end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed 8x8/3-stage cases plus random
// streams on 16x16/4-stage and 5x5/2-stage against a queue scoreboard.
module tb_wallace_mult_pipe;
  typedef longint unsigned u64;
  localparam int NTX = 10000;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  u64   exp_q [3][$];
  u64   got_q [$];
  u64   lit [$];
  int   acc [3];
  bit   stall [3];
  u64   prev [3];

  wallace_mult_pipe_if #(.WIDTH(8))  d0 ();
  wallace_mult_pipe_if #(.WIDTH(16)) d1 ();
  wallace_mult_pipe_if #(.WIDTH(5))  d2 ();

  wallace_mult_pipe #(.WIDTH(8), .STAGES(3)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(d0.slave));
  wallace_mult_pipe #(.WIDTH(16), .STAGES(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(d1.slave));
  wallace_mult_pipe #(.WIDTH(5), .STAGES(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(d2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic u64 ent(input bit s, input u64 p);
    return (u64'(s) << 40) | p;
  endfunction

  function automatic u64 model(input u64 a, input u64 b,
                               input bit s, input int w);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa -= longint'(1) << w;
    if (s && b[w-1]) sb -= longint'(1) << w;
    return ent(s, u64'(sa * sb) & ((u64'(1) << (2 * w)) - 1));
  endfunction

  function automatic u64 gen_op(input int w);
    u64 m;
    m = (u64'(1) << w) - 1;
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return m;
      3: return u64'(1) << (w - 1);
      4: return m >> 1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic chk(input string name, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input int w, input bit rl,
                     input bit iv, input bit ir, input bit ov,
                     input bit orr, input bit si, input bit so,
                     input u64 a, input u64 b, input u64 p);
    u64 cur;
    cur = ent(so, p);
    if (!rl) begin
      chk($sformatf("d%0d valid in reset", id), u64'(ov), 0);
      exp_q[id].delete();
      stall[id] = 0;
      return;
    end
    chk($sformatf("d%0d ready rule", id), u64'(ir), u64'(!ov || orr));
    if (stall[id])
      chk($sformatf("d%0d hold", id), cur | (u64'(ov) << 48),
          prev[id] | (u64'(1) << 48));
    if (ov) begin
      if (exp_q[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d%0d spurious: got %0h, want none", id, cur);
      end else begin
        chk($sformatf("d%0d product", id), cur, exp_q[id][0]);
        if (orr) begin
          void'(exp_q[id].pop_front());
          if (id == 0) got_q.push_back(cur);
        end
      end
    end
    stall[id] = ov && !orr;
    prev[id]  = cur;
    if (iv && ir) begin
      exp_q[id].push_back(model(a, b, si, w));
      acc[id]++;
    end
  endtask

  always @(negedge clk)
    mon(0, 8, rst_n, d0.in_valid_i, d0.in_ready_o, d0.out_valid_o,
        d0.out_ready_i, d0.signed_i, d0.signed_o, u64'(d0.multiplier_i),
        u64'(d0.multiplicand_i), u64'(d0.product_o));
  always @(negedge clk)
    mon(1, 16, rst_n, d1.in_valid_i, d1.in_ready_o, d1.out_valid_o,
        d1.out_ready_i, d1.signed_i, d1.signed_o, u64'(d1.multiplier_i),
        u64'(d1.multiplicand_i), u64'(d1.product_o));
  always @(negedge clk)
    mon(2, 5, rst_n, d2.in_valid_i, d2.in_ready_o, d2.out_valid_o,
        d2.out_ready_i, d2.signed_i, d2.signed_o, u64'(d2.multiplier_i),
        u64'(d2.multiplicand_i), u64'(d2.product_o));

  task automatic drv0(input bit v, input u64 a, input u64 b, input bit s);
    d0.in_valid_i     = v;
    d0.multiplier_i   = 8'(a);
    d0.multiplicand_i = 8'(b);
    d0.signed_i       = s;
  endtask

  task automatic send0(input u64 a, input u64 b, input bit s);
    int n;
    n = 0;
    drv0(1'b1, a, b, s);
    @(negedge clk);
    while (!d0.in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send0 wait", u64'(n < 100), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (exp_q[0].size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("d0 drain", u64'(exp_q[0].size()), 0);
  endtask

  task automatic check_got(input string name);
    chk({name, " count"}, u64'(got_q.size()), u64'(lit.size()));
    foreach (lit[i])
      if (i < got_q.size())
        chk($sformatf("%s #%0d", name, i), got_q[i], lit[i]);
    got_q.delete();
    lit.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv0(1'b0, 0, 0, 1'b0);
    d0.out_ready_i    = 1'b0;
    d1.in_valid_i     = 1'b0;
    d1.multiplier_i   = '0;
    d1.multiplicand_i = '0;
    d1.signed_i       = 1'b0;
    d1.out_ready_i    = 1'b1;
    d2.in_valid_i     = 1'b0;
    d2.multiplier_i   = '0;
    d2.multiplicand_i = '0;
    d2.signed_i       = 1'b0;
    d2.out_ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", u64'(d0.out_valid_o), 0);
    chk("rst product", u64'(d0.product_o), 0);
    chk("rst signed", u64'(d0.signed_o), 0);
    chk("rst in_ready", u64'(d0.in_ready_o), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after release", u64'(d0.in_ready_o), 1);
    d0.out_ready_i = 1'b1;

    drv0(1'b1, 255, 10, 1'b0);
    @(posedge clk); #1;
    chk("latency N", u64'(d0.out_valid_o), 0);
    drv0(1'b1, 63, 101, 1'b0);
    @(posedge clk); #1;
    chk("latency N+1", u64'(d0.out_valid_o), 0);
    drv0(1'b1, 155, 255, 1'b0);
    @(posedge clk); #1;
    chk("latency N+2", u64'(d0.out_valid_o), 1);
    chk("u 255*10", u64'(d0.product_o), 2550);
    drv0(1'b1, 255, 255, 1'b0);
    @(posedge clk); #1;
    chk("u 63*101", u64'(d0.product_o), 6363);
    drv0(1'b0, 0, 0, 1'b0);
    @(posedge clk); #1;
    chk("u 155*255", u64'(d0.product_o), 39525);
    @(posedge clk); #1;
    chk("u 255*255", u64'(d0.product_o), 65025);
    @(posedge clk); #1;
    chk("u stream end", u64'(d0.out_valid_o), 0);
    got_q.delete();

    send0(8'hFF, 8'h0A, 1'b1); lit.push_back(ent(1, 16'hFFF6));
    send0(8'h80, 8'h80, 1'b0); lit.push_back(ent(0, 16'h4000));
    send0(8'h80, 8'h80, 1'b1); lit.push_back(ent(1, 16'h4000));
    send0(8'h80, 8'h7F, 1'b1); lit.push_back(ent(1, 16'hC080));
    send0(8'hFF, 8'hFF, 1'b0); lit.push_back(ent(0, 16'hFE01));
    send0(8'h7F, 8'h7F, 1'b1); lit.push_back(ent(1, 16'h3F01));
    send0(8'hFF, 8'hFF, 1'b1); lit.push_back(ent(1, 16'h0001));
    send0(8'h01, 8'h80, 1'b1); lit.push_back(ent(1, 16'hFF80));
    d0.in_valid_i = 1'b0;
    drain0();
    check_got("mixed mode");

    fork
      begin
        send0(12, 13, 1'b0);       lit.push_back(ent(0, 16'h009C));
        send0(200, 3, 1'b0);       lit.push_back(ent(0, 16'h0258));
        send0(8'hF0, 8'h02, 1'b1); lit.push_back(ent(1, 16'hFFE0));
        send0(8'h01, 8'h80, 1'b1); lit.push_back(ent(1, 16'hFF80));
        send0(8'h00, 8'hFF, 1'b1); lit.push_back(ent(1, 16'h0000));
        send0(8'hFF, 8'h01, 1'b0); lit.push_back(ent(0, 16'h00FF));
        d0.in_valid_i = 1'b0;
      end
      begin
        d0.out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("bp in_ready %0d", i), u64'(d0.in_ready_o), 0);
          chk($sformatf("bp out_valid %0d", i), u64'(d0.out_valid_o), 1);
        end
        @(posedge clk); #1;
        d0.out_ready_i = 1'b1;
      end
    join
    drain0();
    check_got("backpressure");

    send0(8'h80, 8'h7F, 1'b1);
    send0(8'h11, 8'h22, 1'b0);
    send0(8'h33, 8'h44, 1'b1);
    d0.in_valid_i = 1'b0;
    chk("pre-reset valid", u64'(d0.out_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", u64'(d0.out_valid_o), 0);
    chk("async rst product", u64'(d0.product_o), 0);
    chk("async rst signed", u64'(d0.signed_o), 0);
    d0.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", u64'(d0.in_ready_o), 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("no stale %0d", i), u64'(d0.out_valid_o), 0);
      @(posedge clk); #1;
    end
    d0.out_ready_i = 1'b1;

    fork
      begin
        int cyc;
        cyc = 0;
        while (acc[1] < NTX && cyc < 40000) begin
          if (cyc == 1000) chk("d1 full rate", u64'(acc[1]), 1000);
          d1.in_valid_i     = (cyc < 1000) || ($urandom_range(0, 3) != 0);
          d1.multiplier_i   = 16'(gen_op(16));
          d1.multiplicand_i = 16'(gen_op(16));
          d1.signed_i       = 1'($urandom_range(0, 1));
          d1.out_ready_i    = (cyc < 1000) || ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
          cyc++;
        end
        d1.in_valid_i  = 1'b0;
        d1.out_ready_i = 1'b1;
        chk("d1 accepted", u64'(acc[1] >= NTX ? NTX : acc[1]), NTX);
      end
      begin
        int cyc;
        cyc = 0;
        while (acc[2] < NTX && cyc < 40000) begin
          if (cyc == 1000) chk("d2 full rate", u64'(acc[2]), 1000);
          d2.in_valid_i     = (cyc < 1000) || ($urandom_range(0, 3) != 0);
          d2.multiplier_i   = 5'(gen_op(5));
          d2.multiplicand_i = 5'(gen_op(5));
          d2.signed_i       = 1'($urandom_range(0, 1));
          d2.out_ready_i    = (cyc < 1000) || ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
          cyc++;
        end
        d2.in_valid_i  = 1'b0;
        d2.out_ready_i = 1'b1;
        chk("d2 accepted", u64'(acc[2] >= NTX ? NTX : acc[2]), NTX);
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("d1 leftover", u64'(exp_q[1].size()), 0);
    chk("d2 leftover", u64'(exp_q[2].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
